// File: rtl/stream_deserializer_pkg.sv
// Shared helpers for the stream deserializer: index-width math for the beat counter.
package stream_deserializer_pkg;

  // Width needed to index n items; a single item still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_deserializer.sv
// Narrow-to-wide stream converter: packs Ratio narrow beats (lane 0 first) into one wide word,
// with early close on narrow_last_i and valid/ready handshakes on both sides.
//
//   state | meaning
//   FILL  | assembling lanes, wide_valid_o low
//   HOLD  | wide word presented, stable until the wide handshake
module stream_deserializer
  import stream_deserializer_pkg::*;
#(
  parameter int unsigned NarrowWidth = 8,
  parameter int unsigned Ratio       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         narrow_valid_i,
  output logic                         narrow_ready_o,
  input  logic [NarrowWidth-1:0]       narrow_data_i,
  input  logic                         narrow_last_i,
  output logic                         wide_valid_o,
  input  logic                         wide_ready_i,
  output logic [NarrowWidth*Ratio-1:0] wide_data_o,
  output logic [Ratio-1:0]             wide_strb_o,
  output logic                         wide_last_o
);

  localparam int unsigned CntWidth = idx_width(Ratio);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Ratio - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                       state_q, state_d;
  logic [CntWidth-1:0]          cnt_q, cnt_d;
  logic [NarrowWidth*Ratio-1:0] data_q, data_d;
  logic [Ratio-1:0]             strb_q, strb_d;
  logic                         last_q, last_d;
  logic                         accept;

  assign narrow_ready_o = !flush_i && ((state_q == FILL) || wide_ready_i);
  assign accept         = narrow_valid_i && narrow_ready_o;

  assign wide_valid_o = (state_q == HOLD);
  assign wide_data_o  = data_q;
  assign wide_strb_o  = strb_q;
  assign wide_last_o  = last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;

    if (flush_i) begin
      state_d = FILL;
      cnt_d   = '0;
      data_d  = '0;
      strb_d  = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < int'(Ratio); k++) begin
              if (cnt_q == CntWidth'(k)) begin
                data_d[k*NarrowWidth +: NarrowWidth] = narrow_data_i;
                strb_d[k]                            = 1'b1;
              end
            end
            if ((cnt_q == LastCnt) || narrow_last_i) begin
              state_d = HOLD;
              last_d  = narrow_last_i;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntWidth'(1);
            end
          end
        end
        HOLD: begin
          if (wide_ready_i) begin
            state_d = FILL;
            cnt_d   = '0;
            data_d  = '0;
            strb_d  = '0;
            last_d  = 1'b0;
            // Beat arriving alongside the wide handshake starts the next word without a bubble.
            if (accept) begin
              data_d[NarrowWidth-1:0] = narrow_data_i;
              strb_d[0]               = 1'b1;
              if ((Ratio == 1) || narrow_last_i) begin
                state_d = HOLD;
                last_d  = narrow_last_i;
              end else begin
                cnt_d = CntWidth'(1);
              end
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
    end
  end

  logic [Ratio-1:0] strb_inc;
  assign strb_inc = strb_q + Ratio'(1);

  held_word_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (wide_valid_o && !wide_ready_i && !flush_i) |=>
      ($stable(wide_data_o) && $stable(wide_strb_o) && $stable(wide_last_o) && wide_valid_o));

  strb_contiguous: assert property (@(posedge clk_i) disable iff (rst_i)
    ((strb_q & strb_inc) == '0));

endmodule

// File: tb/tb_stream_deserializer.sv
// Directed bench for stream_deserializer: Ratio=4 instance for framing/backpressure/flush,
// Ratio=1 instance for the pass-through register behaviour.
module tb_stream_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fl, nv, nl, wr;
  logic [7:0]  nd;
  logic        nr, wv, wl;
  logic [31:0] wd;
  logic [3:0]  ws;

  logic        f1, n1v, n1l, w1r;
  logic [7:0]  n1d;
  logic        n1r, w1v, w1l;
  logic [7:0]  w1d;
  logic [0:0]  w1s;

  int tests = 0;
  int fails = 0;

  stream_deserializer #(.NarrowWidth(8), .Ratio(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(fl),
    .narrow_valid_i(nv), .narrow_ready_o(nr), .narrow_data_i(nd), .narrow_last_i(nl),
    .wide_valid_o(wv), .wide_ready_i(wr), .wide_data_o(wd), .wide_strb_o(ws), .wide_last_o(wl)
  );

  stream_deserializer #(.NarrowWidth(8), .Ratio(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(f1),
    .narrow_valid_i(n1v), .narrow_ready_o(n1r), .narrow_data_i(n1d), .narrow_last_i(n1l),
    .wide_valid_o(w1v), .wide_ready_i(w1r), .wide_data_o(w1d), .wide_strb_o(w1s), .wide_last_o(w1l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fw [4];

  initial begin
    rst = 1'b1; fl = 1'b0; nv = 1'b0; nl = 1'b0; wr = 1'b0; nd = '0;
    f1 = 1'b0; n1v = 1'b0; n1l = 1'b0; w1r = 1'b0; n1d = '0;
    fw[0] = 8'hA0; fw[1] = 8'hB1; fw[2] = 8'hC2; fw[3] = 8'hD3;

    repeat (2) tick();
    check("rst_valid", wv, 0);
    check("rst_data", wd, 0);
    check("rst_strb", ws, 0);
    check("rst_last", wl, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", nr, 1);

    // reset two beats into a word
    nv = 1'b1; nd = 8'hEE; tick();
    nd = 8'hEF; tick();
    nv = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("midrst_valid", wv, 0);
    check("midrst_data", wd, 0);
    check("midrst_strb", ws, 0);
    for (int i = 0; i < 4; i++) begin
      nv = 1'b1; nd = 8'((i + 1) * 8'h11); tick();
    end
    nv = 1'b0;
    check("midrst_word_valid", wv, 1);
    check("midrst_word_data", wd, 32'h44332211);
    check("midrst_word_strb", ws, 4'hF);
    wr = 1'b1; tick(); wr = 1'b0;
    check("drain_valid", wv, 0);
    check("drain_data", wd, 0);

    // full word, valid one cycle after fourth beat
    for (int i = 0; i < 4; i++) begin
      nv = 1'b1; nd = fw[i]; tick();
      if (i == 2) check("full_latency", wv, 0);
    end
    nv = 1'b0;
    check("full_valid", wv, 1);
    check("full_data", wd, 32'hD3C2B1A0);
    check("full_strb", ws, 4'hF);
    check("full_last", wl, 0);

    // backpressure in HOLD
    nv = 1'b1; nd = 8'h99; wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", nr, 0);
      tick();
      check("bp_data", wd, 32'hD3C2B1A0);
      check("bp_valid", wv, 1);
    end

    // release: 8 beats, two words, no bubbles
    wr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      nd = 8'(i); nv = 1'b1;
      #1;
      check("rel_ready", nr, 1);
      tick();
      if (i == 1) begin
        check("rel_first_valid", wv, 0);
        check("rel_first_data", wd, 32'h00000001);
        check("rel_first_strb", ws, 4'h1);
      end
      if (i == 4) begin
        check("rel_w0_valid", wv, 1);
        check("rel_w0_data", wd, 32'h04030201);
      end
      if (i == 8) begin
        check("rel_w1_valid", wv, 1);
        check("rel_w1_data", wd, 32'h08070605);
      end
    end

    // wide handshake and narrow beat in the same cycle
    nd = 8'h77; nv = 1'b1; wr = 1'b1; tick();
    check("sim_valid", wv, 0);
    check("sim_data", wd, 32'h00000077);
    check("sim_strb", ws, 4'h1);
    wr = 1'b0;
    nd = 8'h88; tick();
    nd = 8'h99; tick();
    nd = 8'hAA; tick();
    nv = 1'b0;
    check("sim_word", wd, 32'hAA998877);
    check("sim_word_valid", wv, 1);
    wr = 1'b1; tick(); wr = 1'b0;
    check("sim_drain", wv, 0);

    // short word closed by last
    nv = 1'b1; nd = 8'h5A; nl = 1'b0; tick();
    nd = 8'h6B; nl = 1'b1; tick();
    nv = 1'b0; nl = 1'b0;
    check("short_valid", wv, 1);
    check("short_data", wd, 32'h00006B5A);
    check("short_strb", ws, 4'h3);
    check("short_last", wl, 1);

    // handshake plus single-beat last frame: straight back to HOLD
    nv = 1'b1; nd = 8'hC3; nl = 1'b1; wr = 1'b1; tick();
    nv = 1'b0; nl = 1'b0;
    check("one_valid", wv, 1);
    check("one_data", wd, 32'h000000C3);
    check("one_strb", ws, 4'h1);
    check("one_last", wl, 1);
    tick(); wr = 1'b0;
    check("one_drain_valid", wv, 0);
    check("one_drain_last", wl, 0);

    // last on the final lane
    nv = 1'b1;
    nd = 8'h10; tick();
    nd = 8'h20; tick();
    nd = 8'h30; tick();
    nd = 8'h40; nl = 1'b1; tick();
    nv = 1'b0; nl = 1'b0;
    check("lastfull_data", wd, 32'h40302010);
    check("lastfull_strb", ws, 4'hF);
    check("lastfull_last", wl, 1);

    // flush while holding with wide_ready high
    fl = 1'b1; wr = 1'b1; nv = 1'b1; nd = 8'h55;
    #1;
    check("flush_ready", nr, 0);
    tick();
    fl = 1'b0; nv = 1'b0; wr = 1'b0;
    check("flush_valid", wv, 0);
    check("flush_data", wd, 0);
    check("flush_strb", ws, 0);
    check("flush_last", wl, 0);

    // flush mid-fill discards the partial lane
    nv = 1'b1; nd = 8'hE1; tick();
    nv = 1'b0; fl = 1'b1; tick();
    fl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nv = 1'b1; nd = 8'((i + 1) * 8'h11); tick();
    end
    nv = 1'b0;
    check("flushfill_data", wd, 32'h44332211);
    check("flushfill_strb", ws, 4'hF);
    wr = 1'b1; tick(); wr = 1'b0;

    // Ratio=1 pass-through
    w1r = 1'b1; n1v = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n1d = 8'(i);
      #1;
      check("r1_ready", n1r, 1);
      tick();
      check("r1_valid", w1v, 1);
      check("r1_data", w1d, 8'(i));
    end
    check("r1_strb", w1s, 1);
    w1r = 1'b0; n1d = 8'hFF;
    #1;
    check("r1_bp_ready", n1r, 0);
    tick();
    check("r1_bp_data", w1d, 8'h10);
    f1 = 1'b1; w1r = 1'b1; tick();
    f1 = 1'b0; n1v = 1'b0; w1r = 1'b0;
    check("r1_flush_valid", w1v, 0);
    check("r1_flush_data", w1d, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
